// File: rtl/booth_multiplier_pkg.sv
// booth_multiplier_pkg: shared state encoding, data width and iteration counts for the Booth multiplier.
package booth_multiplier_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int ITER_R2 = 32;
    localparam int ITER_R4 = 16;
endpackage

// File: rtl/booth_multiplier_cl_adder.sv
// cl_adder: 32-bit add with carry-in and signed-overflow flag, built from generate/propagate terms.
module cl_adder
    import booth_multiplier_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);
    logic [WIDTH:0] c;
    logic [WIDTH-1:0] g, p;
    assign g = a & b;
    assign p = a ^ b;
    assign c[0] = cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign c[i+1] = g[i] | (p[i] & c[i]);
    end
    assign sum = p ^ c[WIDTH-1:0];
    assign overflow = c[WIDTH] ^ c[WIDTH-1];
endmodule

// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential radix-2 Booth multiplier (IDLE/RUN/DONE).
// Define BOOTH_MULT_RADIX4_EN for radix-4 recoding with 16 iterations.
module booth_multiplier
    import booth_multiplier_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_mult,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
`ifdef BOOTH_MULT_RADIX4_EN
    localparam int HW = WIDTH + 2;
    localparam int ITERS = ITER_R4;
`else
    localparam int HW = WIDTH;
    localparam int ITERS = ITER_R2;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS);

    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [HW-1:0] hi, hi_nx;
    logic [WIDTH-1:0] m, lo, lo_nx;
    logic q, q_nx, exc, finish;

`ifdef BOOTH_MULT_RADIX4_EN
    logic [2:0] trip;
    logic [HW-1:0] m_ext, addend, sum;
    assign trip = {lo[1:0], q};
    assign m_ext = {{2{m[WIDTH-1]}}, m};
    assign addend = (trip == 3'b001 || trip == 3'b010) ? m_ext :
                    (trip == 3'b011) ? m_ext << 1 :
                    (trip == 3'b100) ? -(m_ext << 1) :
                    (trip == 3'b101 || trip == 3'b110) ? -m_ext : '0;
    assign sum = hi + addend;
    assign hi_nx = {{2{sum[HW-1]}}, sum[HW-1:2]};
    assign lo_nx = {sum[1:0], lo[WIDTH-1:2]};
    assign q_nx = lo[1];
`else
    logic [WIDTH-1:0] add_b, sum;
    logic add_cin, ovf;
    assign add_cin = lo[0] & ~q;
    assign add_b = (lo[0] ^ q) ? (add_cin ? ~m : m) : '0;
    cl_adder u_adder (
        .a(hi),
        .b(add_b),
        .cin(add_cin),
        .sum(sum),
        .overflow(ovf)
    );
    // Overflow-corrected sign keeps M = 0x80000000 exact through the shift.
    assign hi_nx = {sum[WIDTH-1] ^ ovf, sum[WIDTH-1:1]};
    assign lo_nx = {sum[0], lo[WIDTH-1:1]};
    assign q_nx = lo[0];
`endif

    assign finish = (state == RUN) && (cnt == LAST);
    assign exc = ~(&{hi, lo[WIDTH-1]}) & (|{hi, lo[WIDTH-1]});
    assign data_resultRDY = (state == DONE);

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = ctrl_mult ? RUN :
                   finish ? DONE :
                   (state == DONE) ? IDLE : state;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            m <= '0;
            hi <= '0;
            lo <= '0;
            q <= 1'b0;
            cnt <= '0;
            data_result <= '0;
            data_exception <= 1'b0;
        end else if (ctrl_mult) begin
            m <= data_operandA;
            hi <= '0;
            lo <= data_operandB;
            q <= 1'b0;
            cnt <= '0;
        end else if (finish) begin
            data_result <= lo;
            data_exception <= exc;
        end else if (state == RUN) begin
            hi <= hi_nx;
            lo <= lo_nx;
            q <= q_nx;
            cnt <= cnt + 1'b1;
        end
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: random and directed checks of booth_multiplier against a signed-product model.
module tb_booth_multiplier;
`ifdef BOOTH_MULT_RADIX4_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif
    logic clock, reset_n, ctrl_mult;
    logic [31:0] data_operandA, data_operandB, data_result;
    logic data_exception, data_resultRDY;
    int n_cmp = 0;
    int n_err = 0;

    booth_multiplier dut (
        .clock(clock),
        .reset_n(reset_n),
        .ctrl_mult(ctrl_mult),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .data_result(data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {exception, low word} from the exact 64-bit signed product
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return {p != longint'($signed(p[31:0])), p[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 200)) - 32'd100;
            default: return $urandom;
        endcase
    endfunction

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_mult = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_mult = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] e;
        int n;
        e = model(a, b);
        n = 0;
        start(a, b);
        while (!data_resultRDY && n < LAT + 10) begin
            @(negedge clock);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(LAT));
        check({tag, " result"}, 64'(data_result), 64'(e[31:0]));
        check({tag, " exception"}, 64'(data_exception), 64'(e[32]));
        @(negedge clock);
        check({tag, " rdy_pulse"}, 64'(data_resultRDY), 64'(0));
        check({tag, " hold"}, 64'(data_result), 64'(e[31:0]));
    endtask

    initial begin
        int rdy_seen;
        reset_n = 1'b0;
        ctrl_mult = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #1;
        check("reset result", 64'(data_result), 64'(0));
        check("reset exception", 64'(data_exception), 64'(0));
        check("reset rdy", 64'(data_resultRDY), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        run_op("3x4", 32'd3, 32'd4);
        run_op("-7x6", -32'sd7, 32'd6);
        run_op("max_x2", 32'h7FFF_FFFF, 32'd2);
        run_op("min_x_neg1", 32'h8000_0000, 32'hFFFF_FFFF);
        start(32'd5, 32'd5);
        rdy_seen = 0;
        repeat (9) begin
            @(negedge clock);
            rdy_seen += int'(data_resultRDY);
        end
        check("abort early_rdy", 64'(rdy_seen), 64'(0));
        run_op("restart", 32'd2, -32'sd3);
        start(32'd7, 32'd9);
        repeat (19) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midreset result", 64'(data_result), 64'(0));
        check("midreset exception", 64'(data_exception), 64'(0));
        check("midreset rdy", 64'(data_resultRDY), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        rdy_seen = 0;
        repeat (LAT + 10) begin
            @(negedge clock);
            rdy_seen += int'(data_resultRDY);
        end
        check("post_reset rdy", 64'(rdy_seen), 64'(0));
        @(posedge clock);
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        run_op("first_edge", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 40; i++) run_op($sformatf("rand%0d", i), pick(), pick());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
